ob_table_q: RTL
===============

Name: ob_table_q

Overview:
- Parametrised successor of the single-port bid/ask price table, with a registered command/response handshake.
- Holds up to N resting orders sorted by price priority, and by time priority within a price.
- Supports insert, cancel-by-UID, amend-by-UID and head pop; evicted or rejected entries go to a single reject slot with a pop handshake.
- Sits between the order-book controller and the match engine, one instance per side.

Parameters:
- N, 16, table depth (entries); N >= 2.
- IS_ASK, 1: 1 = ask side (lowest price at head); 0 = bid side (highest price at head).
- CNT_W, $clog2(N+1), width of occupancy count.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_vld  in  1  command valid
- cmd_rdy  out  1  command ready
- cmd_op  in  2  operation: 00 INSERT, 01 CANCEL, 10 AMEND, 11 POP
- cmd_tbl  in  ob_pkg::table_t  payload (price/uid/quantity)
- rsp_vld_r  out  1  response pulse, one cycle after accept
- rsp_hit_r  out  1  operation succeeded
- rsp_tbl_r  out  ob_pkg::table_t  affected entry (cancelled/amended-old/popped/inserted)
- head_vld_r  out  1  head entry valid
- head_r  out  ob_pkg::table_t  best entry
- reject_vld_r  out  1  reject slot occupied
- reject_r  out  ob_pkg::table_t  rejected/evicted entry
- reject_pop  in  1  consumer removes reject entry
- count_r  out  CNT_W  valid entries
- full_r  out  1  count_r == N
- empty_r  out  1  count_r == 0

Behaviour:
- Reset (async, rst_n low):
  - All entries invalid; price = PRICE_MAX if IS_ASK, else PRICE_MIN.
  - rsp_vld_r = 0, rsp_hit_r = 0, rsp_tbl_r = 0.
  - head_vld_r = 0, head_r = 0.
  - reject_vld_r = 0, reject_r = 0.
  - count_r = 0, full_r = 0, empty_r = 1.
  - Reset mid-operation discards any pending response and the reject entry.
- Handshake:
  - Accept occurs when cmd_vld & cmd_rdy.
  - cmd_rdy = ~reject_vld_r | reject_pop; it does not depend on cmd_op.
  - At most one command per cycle.
  - Table, count, head and reject all update on the accept edge; the response is visible the following cycle (latency 1).
- Ordering and positions:
  - Entry 0 is the head; valid entries are contiguous from 0.
  - "Better" means strictly lower price (ask) or strictly higher price (bid).
  - An insert is placed after all valid entries with an equal or better price (FIFO within a price level).
- INSERT:
  - cmd_tbl.price == INVALID price: hit = 0, no state change.
  - Not full: shift down and insert; count +1; hit = 1.
  - Full, new entry better than tail: tail evicted to reject slot, new entry inserted; count unchanged; hit = 1.
  - Full otherwise (including equal price): new entry goes to reject slot; hit = 0.
- CANCEL:
  - Match on uid among valid entries; remove the match and shift later entries up; count -1; hit = 1; rsp_tbl_r = removed entry.
  - No match: hit = 0, rsp_tbl_r = 0.
- AMEND: see Optional Feature.
- POP:
  - Non-empty: remove entry 0 and shift up; rsp_tbl_r = old head; hit = 1.
  - Empty: hit = 0, no change.
- Reject slot:
  - reject_pop with reject_vld_r clears the slot that edge.
  - If a reject/eviction also occurs that edge, the new entry is loaded and reject_vld_r stays 1.
  - reject_pop when the slot is empty is ignored.
- head_r / head_vld_r are the registered entry 0 and its valid bit, updated whenever entry 0 changes.
- UIDs are unique per table by caller contract. Duplicate-UID inserts are out of scope; the bench must not generate them.
- count_r never exceeds N and never underflows.

Optional Feature:
- Macro: OB_TABLE_Q_AMEND_EN.
- Defined, AMEND matches on uid:
  - cmd_tbl.quantity == 0: behaves exactly as CANCEL.
  - Otherwise: replaces the quantity only; position and time priority retained; rsp_tbl_r = pre-amend entry; hit = 1.
  - No match: hit = 0.
- Undefined: AMEND is accepted, table unchanged, rsp_vld_r pulses with hit = 0.

Test Plan:
- N=4, ask; reset, insert prices 105, 100, 103 (uids 1, 2, 3) -> head uid 2 price 100; order 2, 3, 1; count_r = 3; empty_r = 0.
- Insert uid 4 at 103 -> placed after uid 3; full_r = 1. Insert uid 5 at 101 -> uid 1 (105) evicted to reject; reject_vld_r = 1; cmd_rdy = 0 until reject_pop.
- Full with reject slot empty, insert uid 6 at 110 -> reject_r.uid = 6; hit = 0; table unchanged.
- Cancel uid 3 -> hit = 1, rsp_tbl_r.uid = 3, count 4 -> 3. Cancel uid 99 -> hit = 0. POP on empty table -> hit = 0.
- With OB_TABLE_Q_AMEND_EN: amend uid 5 qty 7 -> position unchanged, quantity 7. Amend qty 0 -> removed. Without the macro -> hit = 0, no change.
- reject_pop and an eviction in the same cycle -> reject_r holds the new evictee, reject_vld_r stays 1; rst_n pulse mid-sequence -> all outputs at reset values.

Source files
------------

// File: rtl/ob_table_q.sv
// rtl/ob_table_q.sv - price/time-priority order table with registered cmd/rsp handshake and reject slot
// Optional AMEND support is enabled by defining OB_TABLE_Q_AMEND_EN.
package ob_pkg;
    typedef logic [15:0] price_t;
    typedef logic [15:0] uid_t;
    typedef logic [15:0] qty_t;

    localparam price_t PRICE_MAX = 16'hFFFF;
    localparam price_t PRICE_MIN = 16'h0000;

    typedef struct packed {
        price_t price;
        uid_t   uid;
        qty_t   quantity;
    } table_t;
endpackage

module ob_table_q
    import ob_pkg::*;
#(
    parameter int N      = 16,
    parameter bit IS_ASK = 1'b1,
    parameter int CNT_W  = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_vld,
    output logic             cmd_rdy,
    input  logic [1:0]       cmd_op,
    input  table_t           cmd_tbl,
    output logic             rsp_vld_r,
    output logic             rsp_hit_r,
    output table_t           rsp_tbl_r,
    output logic             head_vld_r,
    output table_t           head_r,
    output logic             reject_vld_r,
    output table_t           reject_r,
    input  logic             reject_pop,
    output logic [CNT_W-1:0] count_r,
    output logic             full_r,
    output logic             empty_r
);

    localparam logic [1:0] OP_INSERT = 2'b00;
    localparam logic [1:0] OP_CANCEL = 2'b01;
    localparam logic [1:0] OP_AMEND  = 2'b10;
    localparam logic [1:0] OP_POP    = 2'b11;

    // Invalid slots carry the worst possible price so they never sort ahead of real orders.
    localparam price_t INV_PRICE = IS_ASK ? PRICE_MAX : PRICE_MIN;
    localparam table_t EMPTY_ENT = '{price: INV_PRICE, uid: '0, quantity: '0};

    function automatic logic better(input price_t a, input price_t b);
        return IS_ASK ? (a < b) : (a > b);
    endfunction

    table_t           ent_q [N];
    table_t           ent_d [N];
    table_t           ent_up [N];
    table_t           ent_dn [N];
    logic [N-1:0]     vld_q, vld_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rsp_vld_q, rsp_hit_q;
    table_t           rsp_tbl_q;
    logic             head_vld_q;
    table_t           head_q, head_d;
    logic             rej_vld_q, rej_vld_d;
    table_t           rej_q, rej_d;
    logic             full_q, empty_q;

    logic   accept;
    logic   hit, ins_en, rem_en, amd_en, found, tbl_full, rej_load;
    int     pos, midx, ridx;
    table_t rsp_ent, rej_ent;

    assign cmd_rdy = ~rej_vld_q | reject_pop;
    assign accept  = cmd_vld & cmd_rdy;

    always_comb begin
        for (int i = 0; i < N - 1; i++) begin
            ent_up[i] = ent_q[i + 1];
            ent_dn[i + 1] = ent_q[i];
        end
        ent_up[N-1] = EMPTY_ENT;
        ent_dn[0]   = EMPTY_ENT;
    end

    // Insert position: after every valid entry whose price is equal or better (FIFO within a level).
    always_comb begin
        pos   = 0;
        found = 1'b0;
        midx  = 0;
        for (int i = 0; i < N; i++) begin
            if (vld_q[i] && !better(cmd_tbl.price, ent_q[i].price)) pos = i + 1;
            if (!found && vld_q[i] && ent_q[i].uid == cmd_tbl.uid) begin
                found = 1'b1;
                midx  = i;
            end
        end
    end

    assign tbl_full = vld_q[N-1];

    always_comb begin
        hit      = 1'b0;
        ins_en   = 1'b0;
        rem_en   = 1'b0;
        amd_en   = 1'b0;
        ridx     = 0;
        rej_load = 1'b0;
        rej_ent  = '0;
        rsp_ent  = '0;
        if (accept) begin
            case (cmd_op)
                OP_INSERT: begin
                    rsp_ent = cmd_tbl;
                    if (cmd_tbl.price != INV_PRICE) begin
                        if (!tbl_full || better(cmd_tbl.price, ent_q[N-1].price)) begin
                            ins_en   = 1'b1;
                            hit      = 1'b1;
                            rej_load = tbl_full;
                            rej_ent  = tbl_full ? ent_q[N-1] : '0;
                        end else begin
                            rej_load = 1'b1;
                            rej_ent  = cmd_tbl;
                        end
                    end
                end
                OP_CANCEL: begin
                    if (found) begin
                        rem_en  = 1'b1;
                        ridx    = midx;
                        hit     = 1'b1;
                        rsp_ent = ent_q[midx];
                    end
                end
                OP_AMEND: begin
`ifdef OB_TABLE_Q_AMEND_EN
                    if (found) begin
                        hit     = 1'b1;
                        rsp_ent = ent_q[midx];
                        ridx    = midx;
                        if (cmd_tbl.quantity == '0) rem_en = 1'b1;
                        else                        amd_en = 1'b1;
                    end
`else
                    hit = 1'b0;
`endif
                end
                default: begin
                    if (vld_q[0]) begin
                        rem_en  = 1'b1;
                        hit     = 1'b1;
                        rsp_ent = ent_q[0];
                    end
                end
            endcase
        end
    end

    always_comb begin
        ent_d   = ent_q;
        vld_d   = vld_q;
        count_d = count_q;
        if (ins_en) begin
            for (int i = 0; i < N; i++) begin
                if (i == pos) begin
                    ent_d[i] = cmd_tbl;
                    vld_d[i] = 1'b1;
                end else if (i > pos) begin
                    ent_d[i] = ent_dn[i];
                    vld_d[i] = (i > 0) ? vld_q[i-1] : 1'b0;
                end
            end
            if (!tbl_full) count_d = count_q + 1'b1;
        end else if (rem_en) begin
            for (int i = 0; i < N; i++) begin
                if (i >= ridx) begin
                    ent_d[i] = ent_up[i];
                    vld_d[i] = (i < N - 1) ? vld_q[i+1] : 1'b0;
                end
            end
            count_d = count_q - 1'b1;
        end else if (amd_en) begin
            for (int i = 0; i < N; i++) begin
                if (i == ridx) ent_d[i].quantity = cmd_tbl.quantity;
            end
        end
    end

    // A same-edge eviction wins over reject_pop so the slot stays occupied with the newer entry.
    always_comb begin
        rej_vld_d = rej_load | (rej_vld_q & ~reject_pop);
        rej_d     = rej_q;
        if (rej_load)                    rej_d = rej_ent;
        else if (rej_vld_q & reject_pop) rej_d = '0;
        head_d = vld_d[0] ? ent_d[0] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) ent_q[i] <= EMPTY_ENT;
            vld_q      <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            rsp_vld_q  <= 1'b0;
            rsp_hit_q  <= 1'b0;
            rsp_tbl_q  <= '0;
            head_vld_q <= 1'b0;
            head_q     <= '0;
            rej_vld_q  <= 1'b0;
            rej_q      <= '0;
        end else begin
            ent_q      <= ent_d;
            vld_q      <= vld_d;
            count_q    <= count_d;
            full_q     <= (count_d == CNT_W'(N));
            empty_q    <= (count_d == '0);
            rsp_vld_q  <= accept;
            if (accept) begin
                rsp_hit_q <= hit;
                rsp_tbl_q <= rsp_ent;
            end
            head_vld_q <= vld_d[0];
            head_q     <= head_d;
            rej_vld_q  <= rej_vld_d;
            rej_q      <= rej_d;
        end
    end

    assign rsp_vld_r    = rsp_vld_q;
    assign rsp_hit_r    = rsp_hit_q;
    assign rsp_tbl_r    = rsp_tbl_q;
    assign head_vld_r   = head_vld_q;
    assign head_r       = head_q;
    assign reject_vld_r = rej_vld_q;
    assign reject_r     = rej_q;
    assign count_r      = count_q;
    assign full_r       = full_q;
    assign empty_r      = empty_q;

endmodule
